// File: rtl/grf_wb_sched_pkg.sv
// Shared definitions for the GRF write-port scheduler: register addressing
// and the grant-source encoding used by the port mux.
package grf_wb_sched_pkg;

    localparam int RAW = 5;
    localparam int NREGS = 1 << RAW;
    localparam logic [RAW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LQ   = 2'd2
    } grant_src_t;

endpackage

// File: rtl/grf_wb_sched_fifo.sv
// Late-result buffer: W-bit wide, DEPTH-deep FIFO with occupancy count.
// Storage is not reset; only pointers and count are.
module wb_fifo
    import grf_wb_sched_pkg::*;
#(
    parameter int W     = 69,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grf_wb_sched.sv
// GRF write-port scheduler: pipeline writeback has priority, late results
// drain from a FIFO, and a scoreboard flags registers awaiting a late write.
module grf_wb_sched
    import grf_wb_sched_pkg::*;
#(
    parameter int DW      = 32,
    parameter int QDEPTH  = 2,
    parameter int MAXWAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           p_we,
    input  logic [RAW-1:0] p_a3,
    input  logic [DW-1:0]  p_wd,
    input  logic [31:0]    p_pc,
    input  logic           issue_valid,
    input  logic [RAW-1:0] issue_a3,
    input  logic           lq_valid,
    output logic           lq_ready,
    input  logic [RAW-1:0] lq_a3,
    input  logic [DW-1:0]  lq_wd,
    input  logic [31:0]    lq_pc,
    input  logic [RAW-1:0] a1,
    input  logic [RAW-1:0] a2,
    output logic           rd_pend1,
    output logic           rd_pend2,
    output logic           drain_req,
    output logic           grf_we,
    output logic [RAW-1:0] grf_a3,
    output logic [DW-1:0]  grf_wd,
    output logic [31:0]    grf_pc,
    output logic           err
);

    localparam int EW = DW + RAW + 32;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int WW = $clog2(MAXWAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAIT);

    grant_src_t       src;
    logic [EW-1:0]    head;
    logic [RAW-1:0]   head_a3;
    logic [31:0]      head_pc;
    logic [DW-1:0]    head_wd;
    logic [CW-1:0]    count;
    logic             fifo_full_unused;
    logic             empty;
    logic             push;
    logic             pop;
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic             issue_err;
    logic             push_err;
    logic [WW-1:0]    wait_cnt;

    assign lq_ready = (count < CW'(QDEPTH));
    assign push     = lq_valid && lq_ready && (lq_a3 != REG_ZERO);
    assign pop      = (src == SRC_LQ);
    assign {head_a3, head_pc, head_wd} = head;

    wb_fifo #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({lq_a3, lq_pc, lq_wd}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (fifo_full_unused),
        .empty (empty)
    );

    // Port grant: a live pipeline write always wins; reset silences the port.
    always_comb begin
        src    = SRC_NONE;
        grf_we = 1'b0;
        grf_a3 = REG_ZERO;
        grf_wd = '0;
        grf_pc = '0;
        if (!reset) begin
            if (p_we && (p_a3 != REG_ZERO)) begin
                src    = SRC_PIPE;
                grf_we = 1'b1;
                grf_a3 = p_a3;
                grf_wd = p_wd;
                grf_pc = p_pc;
            end else if (!empty) begin
                src    = SRC_LQ;
                grf_we = 1'b1;
                grf_a3 = head_a3;
                grf_wd = head_wd;
                grf_pc = head_pc;
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (pop) clr_vec[head_a3] = 1'b1;
        if (issue_valid && (issue_a3 != REG_ZERO)) set_vec[issue_a3] = 1'b1;
    end

    // A same-cycle clear makes a re-issue legitimate.
    assign issue_err = set_vec[issue_a3] && pend[issue_a3] && !clr_vec[issue_a3];
    assign push_err  = push && !pend[lq_a3];

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            err  <= 1'b0;
        end else begin
            pend <= ((pend & ~clr_vec) | set_vec) & ~NREGS'(1);
            if (issue_err || push_err) err <= 1'b1;
        end
    end

    // Read-during-write forwarding covers the cycle the late write lands.
    assign rd_pend1 = pend[a1] && !(grf_we && (grf_a3 == a1));
    assign rd_pend2 = pend[a2] && !(grf_we && (grf_a3 == a2));

    always_ff @(posedge clk) begin
        if (reset || empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign drain_req = (wait_cnt == WAIT_MAX);

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed bench for grf_wb_sched: late writes, pipeline priority, FIFO
// back-pressure, $0 and error handling, and reset in mid-operation.
module tb_grf_wb_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic [31:0] p_pc;
    logic        issue_valid;
    logic [4:0]  issue_a3;
    logic        lq_valid;
    logic        lq_ready;
    logic [4:0]  lq_a3;
    logic [31:0] lq_wd;
    logic [31:0] lq_pc;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        rd_pend1;
    logic        rd_pend2;
    logic        drain_req;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grf_wb_sched #(.DW(32), .QDEPTH(2), .MAXWAIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .p_we        (p_we),
        .p_a3        (p_a3),
        .p_wd        (p_wd),
        .p_pc        (p_pc),
        .issue_valid (issue_valid),
        .issue_a3    (issue_a3),
        .lq_valid    (lq_valid),
        .lq_ready    (lq_ready),
        .lq_a3       (lq_a3),
        .lq_wd       (lq_wd),
        .lq_pc       (lq_pc),
        .a1          (a1),
        .a2          (a2),
        .rd_pend1    (rd_pend1),
        .rd_pend2    (rd_pend2),
        .drain_req   (drain_req),
        .grf_we      (grf_we),
        .grf_a3      (grf_a3),
        .grf_wd      (grf_wd),
        .grf_pc      (grf_pc),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns after it, checks follow a settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        p_we = 1'b0; p_a3 = '0; p_wd = '0; p_pc = '0;
        issue_valid = 1'b0; issue_a3 = '0;
        lq_valid = 1'b0; lq_a3 = '0; lq_wd = '0; lq_pc = '0;
    endtask

    task automatic issue(input logic [4:0] r);
        issue_valid = 1'b1; issue_a3 = r;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic lq_set(input logic [4:0] r, input logic [31:0] d);
        lq_valid = 1'b1; lq_a3 = r; lq_wd = d; lq_pc = 32'h1000 + 32'(r);
    endtask

    initial begin
        idle();
        a1 = '0; a2 = '0;
        reset = 1'b1;
        p_we = 1'b1; p_a3 = 5'd3; p_wd = 32'h33;
        settle();
        chk("reset_gate_we", grf_we, 0);
        tick(); tick();
        idle();
        reset = 1'b0;
        settle();
        chk("rst_lq_ready", lq_ready, 1);
        chk("rst_drain", drain_req, 0);
        chk("rst_err", err, 0);
        chk("rst_pend1", rd_pend1, 0);

        // Basic late write to $5
        a1 = 5'd5;
        issue(5'd5);
        settle();
        chk("basic_pend_after_issue", rd_pend1, 1);
        lq_set(5'd5, 32'hDEADBEEF);
        settle();
        chk("basic_ready", lq_ready, 1);
        chk("basic_no_write_yet", grf_we, 0);
        tick();
        lq_valid = 1'b0;
        settle();
        chk("basic_we", grf_we, 1);
        chk("basic_a3", grf_a3, 5);
        chk("basic_wd", grf_wd, 32'hDEADBEEF);
        chk("basic_pc", grf_pc, 32'h1005);
        chk("basic_fwd_nostall", rd_pend1, 0);
        tick();
        settle();
        chk("basic_port_idle", grf_we, 0);
        chk("basic_pend_cleared", rd_pend1, 0);
        chk("basic_err", err, 0);

        // Pipeline priority and starvation of a buffered $7
        a1 = 5'd7;
        issue(5'd7);
        lq_set(5'd7, 32'h77);
        tick();
        lq_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [4:0] regs [4];
            regs = '{5'd3, 5'd4, 5'd9, 5'd10};
            p_we = 1'b1; p_a3 = regs[k]; p_wd = 32'hA0 + 32'(k); p_pc = 32'h200 + 32'(4 * k);
            settle();
            chk("prio_a3", grf_a3, 32'(regs[k]));
            chk("prio_wd", grf_wd, 32'hA0 + 32'(k));
            chk("prio_drain_low", drain_req, 0);
            chk("prio_pend7", rd_pend1, 1);
            tick();
        end
        p_we = 1'b0; p_a3 = '0;
        settle();
        chk("starve_drain_high", drain_req, 1);
        chk("starve_we", grf_we, 1);
        chk("starve_a3", grf_a3, 7);
        chk("starve_wd", grf_wd, 32'h77);
        tick();
        settle();
        chk("starve_drain_fall", drain_req, 0);
        chk("starve_port_idle", grf_we, 0);

        // Full FIFO back-pressure
        issue(5'd1); issue(5'd2); issue(5'd3);
        p_we = 1'b1; p_a3 = 5'd20; p_wd = 32'h20;
        lq_set(5'd1, 32'h1);
        settle();
        chk("full_ready0", lq_ready, 1);
        tick();
        lq_set(5'd2, 32'h2);
        settle();
        chk("full_ready1", lq_ready, 1);
        tick();
        lq_set(5'd3, 32'h3);
        settle();
        chk("full_not_ready", lq_ready, 0);
        tick();
        p_we = 1'b0; p_a3 = '0;
        settle();
        chk("full_pop1_a3", grf_a3, 1);
        chk("full_no_passthru", lq_ready, 0);
        tick();
        settle();
        chk("full_ready_after_pop", lq_ready, 1);
        chk("full_pop2_a3", grf_a3, 2);
        tick();
        lq_valid = 1'b0;
        settle();
        chk("full_third_a3", grf_a3, 3);
        chk("full_third_wd", grf_wd, 3);
        tick();
        settle();
        chk("full_drained", grf_we, 0);
        chk("full_err", err, 0);

        // $0 handling
        p_we = 1'b1; p_a3 = 5'd0; p_wd = 32'h99;
        lq_set(5'd0, 32'h55);
        settle();
        chk("zero_pipe_we", grf_we, 0);
        chk("zero_lq_ready", lq_ready, 1);
        tick();
        idle();
        settle();
        chk("zero_lq_not_queued", grf_we, 0);
        chk("zero_err", err, 0);

        // Same-cycle clear and re-issue of $5, then a true re-issue
        a1 = 5'd5;
        issue(5'd5);
        lq_set(5'd5, 32'h5);
        tick();
        lq_valid = 1'b0;
        issue_valid = 1'b1; issue_a3 = 5'd5;
        settle();
        chk("clrset_write_a3", grf_a3, 5);
        tick();
        issue_valid = 1'b0;
        settle();
        chk("clrset_pending", rd_pend1, 1);
        chk("clrset_no_err", err, 0);
        issue(5'd5);
        settle();
        chk("reissue_err", err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("err_cleared_by_reset", err, 0);

        // Push to a register never issued
        lq_set(5'd12, 32'hC);
        tick();
        lq_valid = 1'b0;
        settle();
        chk("unissued_err", err, 1);
        tick(); tick();
        settle();
        chk("unissued_err_sticky", err, 1);

        // Reset with two buffered entries and pending marks
        a1 = 5'd6; a2 = 5'd8;
        issue(5'd6); issue(5'd8);
        p_we = 1'b1; p_a3 = 5'd20;
        lq_set(5'd6, 32'h6);
        tick();
        lq_set(5'd8, 32'h8);
        tick();
        lq_valid = 1'b0;
        settle();
        chk("mid_pend1", rd_pend1, 1);
        chk("mid_pend2", rd_pend2, 1);
        chk("mid_full", lq_ready, 0);
        p_we = 1'b0; p_a3 = '0;
        reset = 1'b1;
        settle();
        chk("mid_reset_we", grf_we, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("mid_ready", lq_ready, 1);
        chk("mid_pend1_clr", rd_pend1, 0);
        chk("mid_pend2_clr", rd_pend2, 0);
        chk("mid_err_clr", err, 0);
        chk("mid_no_stale_we", grf_we, 0);
        tick();
        settle();
        chk("mid_no_stale_we2", grf_we, 0);
        chk("mid_drain", drain_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
